// File: rtl/mm_mem_arbiter_pkg.sv
// Shared types for the matrix-memory arbiter: FSM encoding, requester id,
// read-return tag and default sizing.
package mm_mem_arbiter_pkg;

  localparam int DEFAULT_N         = 20;
  localparam int DEFAULT_MAX_BURST = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/mm_rr_pick.sv
// Two-way round-robin pick: on a tie the requester that did not own the
// memory last wins.
module mm_rr_pick
  import mm_mem_arbiter_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last_owner,
  output logic    valid,
  output req_id_t id
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      id = ~last_owner;
    end else begin
      id = req1;
    end
  end

endmodule

// File: rtl/mm_mem_arbiter.sv
// Shares one single-port matrix memory between two requesters with
// round-robin arbitration, capped locked bursts and tagged read return.
module mm_mem_arbiter
  import mm_mem_arbiter_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic           lock0,
  input  logic           lock1,
  input  logic           we0,
  input  logic           we1,
  input  logic [N-1:0]   i0,
  input  logic [N-1:0]   i1,
  input  logic [N-1:0]   j0,
  input  logic [N-1:0]   j1,
  input  logic           index0,
  input  logic           index1,
  input  logic [2*N-1:0] wdata0,
  input  logic [2*N-1:0] wdata1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           rvalid0,
  output logic           rvalid1,
  output logic [N-1:0]   rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [N-1:0]   mem_i,
  output logic [N-1:0]   mem_j,
  output logic           mem_index,
  output logic [2*N-1:0] mem_wdata,
  input  logic [N-1:0]   mem_rdata
);

  // Wide enough to hold MAX_BURST itself so the count can saturate there.
  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  arb_state_t    state, state_nxt;
  req_id_t       last_owner, last_owner_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
  rd_tag_t       rd_tag, rd_tag_nxt;

  logic    pick_valid;
  req_id_t pick_id;

  logic    gnt_valid;
  req_id_t gnt_id;
  logic    own_req;
  logic    in_burst;
  logic    gnt_lock;
  logic    gnt_we;
  logic    other_req;
  logic    cap_hit;
  logic [CW-1:0] cnt_after;

  mm_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .id         (pick_id)
  );

  // NOTE: every signal gets a default before any branch so no path leaves
  // a combinational output unassigned and no latch is inferred.
  always_comb begin
    own_req        = 1'b0;
    in_burst       = 1'b0;
    gnt_valid      = 1'b0;
    gnt_id         = 1'b0;
    gnt_lock       = 1'b0;
    gnt_we         = 1'b0;
    other_req      = 1'b0;
    cap_hit        = 1'b0;
    cnt_after      = CW'(1);
    state_nxt      = IDLE;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    rd_tag_nxt     = '0;

    unique case (state)
      OWN0:    own_req = req0;
      OWN1:    own_req = req1;
      default: own_req = 1'b0;
    endcase
    in_burst = (state != IDLE) && own_req;

    // A dropped owner falls through to the idle pick in the same cycle.
    if (in_burst) begin
      gnt_valid = 1'b1;
      gnt_id    = (state == OWN1);
      cnt_after = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CW'(1);
    end else begin
      gnt_valid = pick_valid;
      gnt_id    = pick_id;
      cnt_after = CW'(1);
    end

    gnt_lock  = gnt_id ? lock1 : lock0;
    gnt_we    = gnt_id ? we1 : we0;
    other_req = gnt_id ? req0 : req1;
    cap_hit   = other_req && (cnt_after >= CNT_MAX);

    if (gnt_valid) begin
      last_owner_nxt = gnt_id;
      burst_cnt_nxt  = cnt_after;
      if (gnt_lock && !cap_hit) begin
        state_nxt = gnt_id ? OWN1 : OWN0;
      end
      rd_tag_nxt.valid = !gnt_we;
      rd_tag_nxt.id    = gnt_id;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      rd_tag     <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      rd_tag     <= rd_tag_nxt;
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_i     = '0;
    mem_j     = '0;
    mem_index = 1'b0;
    mem_wdata = '0;

    if (!reset) begin
      gnt0    = gnt_valid && (gnt_id == 1'b0);
      gnt1    = gnt_valid && (gnt_id == 1'b1);
      rvalid0 = rd_tag.valid && (rd_tag.id == 1'b0);
      rvalid1 = rd_tag.valid && (rd_tag.id == 1'b1);
      if (rd_tag.valid) begin
        rdata = mem_rdata;
      end
      if (gnt_valid) begin
        mem_en    = 1'b1;
        mem_we    = gnt_we;
        mem_i     = gnt_id ? i1 : i0;
        mem_j     = gnt_id ? j1 : j0;
        mem_index = gnt_id ? index1 : index0;
        mem_wdata = gnt_id ? wdata1 : wdata0;
      end
    end
  end

endmodule
